// File: rtl/pipe_idecode_pkg.sv
// Shared decode definitions: second-source select codes, extender modes and
// the 32-bit immediate builder used by the decode stage.
package pipe_idecode_pkg;

  localparam logic RF2_RK = 1'b0;
  localparam logic RF2_RD = 1'b1;

  typedef enum logic [2:0] {
    EXT_12S = 3'd0,
    EXT_12U = 3'd1,
    EXT_5U  = 3'd2,
    EXT_20  = 3'd3,
    EXT_16  = 3'd4,
    EXT_26  = 3'd5
  } ext_op_e;

  // val is already extended to 32 bits; sgn says whether to keep extending
  // with val[31] or with zeros when XLEN is wider.
  typedef struct packed {
    logic        sgn;
    logic [31:0] val;
  } imm_t;

  function automatic imm_t ext_imm32(input logic [2:0] op, input logic [31:0] inst);
    imm_t r;
    r = '0;
    case (op)
      EXT_12S: begin r.val = {{20{inst[21]}}, inst[21:10]};               r.sgn = 1'b1; end
      EXT_12U: begin r.val = {20'b0, inst[21:10]};                         r.sgn = 1'b0; end
      EXT_5U:  begin r.val = {27'b0, inst[14:10]};                         r.sgn = 1'b0; end
      EXT_20:  begin r.val = {inst[24:5], 12'b0};                          r.sgn = 1'b1; end
      EXT_16:  begin r.val = {{14{inst[25]}}, inst[25:10], 2'b00};         r.sgn = 1'b1; end
      EXT_26:  begin r.val = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00}; r.sgn = 1'b1; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_idecode_if.sv
// IF/ID input handshake and ID/EX output bundle of the decode stage.
interface pipe_idecode_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid, in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [2:0]      in_sext_op;
  logic            in_rf2_sel, in_use1, in_use2, in_we, in_is_load;

  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_rd1, out_rd2, out_ext;
  logic [AW-1:0]   out_wr;
  logic            out_we, out_is_load;

  modport master (
    output in_valid, in_inst, in_pc, in_sext_op, in_rf2_sel, in_use1, in_use2, in_we, in_is_load,
    input  in_ready,
    input  out_valid, out_pc, out_rd1, out_rd2, out_ext, out_wr, out_we, out_is_load,
    output out_ready
  );

  modport slave (
    input  in_valid, in_inst, in_pc, in_sext_op, in_rf2_sel, in_use1, in_use2, in_we, in_is_load,
    output in_ready,
    output out_valid, out_pc, out_rd1, out_rd2, out_ext, out_wr, out_we, out_is_load,
    input  out_ready
  );
endinterface

// File: rtl/pipe_idecode_rf_bypass.sv
// Register file with r0 hardwired to zero and a same-cycle WB write-through
// on every read port.
module rf_bypass #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic [XLEN-1:0]           wd,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][XLEN-1:0]  rd
);

  logic [NREG-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst)                  regs     <= '0;
    else if (we && wa != '0)  regs[wa] <= wd;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rd[p] = (we && ra[p] != '0 && wa == ra[p]) ? wd : regs[ra[p]];
  end

endmodule

// File: rtl/pipe_idecode.sv
// Pipelined decode stage: RF read, EX/MEM/WB forwarding, immediate extension,
// load-use stall and the ID/EX register with valid/ready handshake.
module pipe_idecode
  import pipe_idecode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  pipe_idecode_if.slave     bus,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [AW-1:0]     ex_wr,
  input  logic [XLEN-1:0]   ex_wd,
  input  logic              mem_we,
  input  logic [AW-1:0]     mem_wr,
  input  logic [XLEN-1:0]   mem_wd,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_wr,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc, rd1, rd2, ext;
    logic [AW-1:0]   wr;
    logic            we, is_load;
  } idex_t;

  logic [1:0][AW-1:0]   src;
  logic [1:0][XLEN-1:0] rf_rd, opnd;
  logic                 haz, adv, out_v;
  imm_t                 imm;
  logic [XLEN-1:0]      ext;
  idex_t                d, q;
  logic                 unused_inst;

  assign src[0] = bus.in_inst[5 +: AW];
  assign src[1] = (bus.in_rf2_sel == RF2_RD) ? bus.in_inst[0 +: AW] : bus.in_inst[10 +: AW];
  assign unused_inst = ^bus.in_inst;

  rf_bypass #(.XLEN(XLEN), .NREG(NREG), .NRD(2)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (wb_we),
    .wa  (wb_wr),
    .wd  (wb_wd),
    .ra  (src),
    .rd  (rf_rd)
  );

  // A load in EX has no data yet, so it is never a forwarding source.
  always_comb begin
    opnd = '0;
    for (int s = 0; s < 2; s++) begin
      if (src[s] == '0)                                      opnd[s] = '0;
      else if (ex_we && !ex_is_load && ex_wr == src[s])      opnd[s] = ex_wd;
      else if (mem_we && mem_wr == src[s])                   opnd[s] = mem_wd;
      else                                                   opnd[s] = rf_rd[s];
    end
  end

  assign imm = ext_imm32(bus.in_sext_op, bus.in_inst);
  assign ext = imm.sgn ? XLEN'($signed(imm.val)) : XLEN'(imm.val);

  assign haz = bus.in_valid && ex_is_load && ex_we && (ex_wr != '0) &&
               ((bus.in_use1 && src[0] == ex_wr) || (bus.in_use2 && src[1] == ex_wr));
  assign adv = bus.out_ready || !out_v;
  assign bus.in_ready = adv && !haz && !flush;

  always_comb begin
    d         = '0;
    d.pc      = bus.in_pc;
    d.rd1     = opnd[0];
    d.rd2     = opnd[1];
    d.ext     = ext;
    d.wr      = bus.in_inst[0 +: AW];
    d.we      = bus.in_we;
    d.is_load = bus.in_is_load;
  end

  // Payload only moves on LOAD; bubbles just drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v     <= 1'b0;
      q         <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush)                               out_v <= 1'b0;
      else if (adv && bus.in_valid && !haz) begin
        out_v <= 1'b1;
        q     <= d;
      end else if (adv)                        out_v <= 1'b0;
      if (haz && !flush) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid   = out_v;
  assign bus.out_pc      = q.pc;
  assign bus.out_rd1     = q.rd1;
  assign bus.out_rd2     = q.rd2;
  assign bus.out_ext     = q.ext;
  assign bus.out_wr      = q.wr;
  assign bus.out_we      = q.we;
  assign bus.out_is_load = q.is_load;

endmodule

// File: tb/tb_pipe_idecode.sv
// Directed scenarios plus a randomized run against a cycle-level model of the
// decode stage (register file contents, forwarding rules, handshake state).
module tb_pipe_idecode;
  import pipe_idecode_pkg::*;

  localparam int XLEN = 32, NREG = 32, CNT_W = 32, AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_idecode_if #(.XLEN(XLEN), .AW(AW)) bus ();
  logic             ex_we, ex_is_load, mem_we, wb_we, flush;
  logic [AW-1:0]    ex_wr, mem_wr, wb_wr;
  logic [XLEN-1:0]  ex_wd, mem_wd, wb_wd;
  logic [CNT_W-1:0] stall_cnt;

  pipe_idecode #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wr(ex_wr), .ex_wd(ex_wd),
    .mem_we(mem_we), .mem_wr(mem_wr), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  int checks = 0, failures = 0;

  // model state
  logic [31:0] rf_m [NREG];
  logic        mv;
  logic [31:0] m_pc, m_rd1, m_rd2, m_ext, m_cnt;
  logic [4:0]  m_wr;
  logic        m_we, m_ld;

  function automatic logic [31:0] add_w(input int rd, input int rj, input int rk);
    return 32'h0010_0000 | (32'(rk) << 10) | (32'(rj) << 5) | 32'(rd);
  endfunction

  function automatic logic [31:0] exp_src(input int r);
    if (r == 0) return 0;
    if (ex_we && !ex_is_load && int'(ex_wr) == r) return ex_wd;
    if (mem_we && int'(mem_wr) == r) return mem_wd;
    if (wb_we && int'(wb_wr) == r) return wb_wd;
    return rf_m[r];
  endfunction

  function automatic logic [31:0] exp_ext(input logic [2:0] op, input logic [31:0] inst);
    int v;
    case (op)
      EXT_12S: begin v = int'((inst >> 10) & 32'hFFF); if (v >= 2048) v -= 4096; end
      EXT_12U: v = int'((inst >> 10) & 32'hFFF);
      EXT_5U:  v = int'((inst >> 10) & 32'h1F);
      EXT_20:  v = int'(((inst >> 5) & 32'hFFFFF) << 12);
      EXT_16:  begin v = int'((inst >> 10) & 32'hFFFF); if (v >= 32768) v -= 65536; v = v * 4; end
      EXT_26:  begin
        v = int'(((inst & 32'h3FF) << 16) | ((inst >> 10) & 32'hFFFF));
        if (v >= (1 << 25)) v -= (1 << 26);
        v = v * 4;
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) for (int i = 0; i < NREG; i++) rf_m[i] = 0;
    else if (wb_we && wb_wr != 0) rf_m[wb_wr] = wb_wd;
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0; bus.in_sext_op = EXT_12S;
    bus.in_rf2_sel = RF2_RK; bus.in_use1 = 0; bus.in_use2 = 0; bus.in_we = 0;
    bus.in_is_load = 0; bus.out_ready = 1;
    ex_we = 0; ex_is_load = 0; ex_wr = 0; ex_wd = 0;
    mem_we = 0; mem_wr = 0; mem_wd = 0; wb_we = 0; wb_wr = 0; wb_wd = 0; flush = 0;
  endtask

  task automatic present(input int rd, input int rj, input int rk, input logic [31:0] pc);
    bus.in_valid = 1; bus.in_inst = add_w(rd, rj, rk); bus.in_pc = pc;
    bus.in_use1 = 1; bus.in_use2 = 1; bus.in_we = 1; bus.in_rf2_sel = RF2_RK;
  endtask

  task automatic test_reset();
    idle(); rst = 1; flush = 1;
    step(); step();
    rst = 0; flush = 0; #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", bus.out_valid); end
    checks++; if (bus.out_we !== 1'b0 || bus.out_wr !== '0) begin failures++; $display("FAIL reset_out_we_wr got=%0d/%0d exp=0/0", bus.out_we, bus.out_wr); end
    checks++; if (bus.out_pc !== '0 || bus.out_rd1 !== '0 || bus.out_ext !== '0) begin failures++; $display("FAIL reset_payload got=%h/%h/%h exp=0", bus.out_pc, bus.out_rd1, bus.out_ext); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", bus.in_ready); end
    present(1, 5, 0, 32'h40); step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rd1 !== 32'h0) begin failures++; $display("FAIL reset_read_r5 got=%0d/%h exp=1/0", bus.out_valid, bus.out_rd1); end
  endtask

  task automatic test_wb_bypass();
    idle(); wb_we = 1; wb_wr = 3; wb_wd = 32'h1234;
    present(1, 3, 4, 32'h80); step();
    checks++; if (bus.out_rd1 !== 32'h1234) begin failures++; $display("FAIL wb_bypass_rd1 got=%h exp=1234", bus.out_rd1); end
    checks++; if (bus.out_wr !== 5'd1 || bus.out_we !== 1'b1 || bus.out_rd2 !== 0) begin failures++; $display("FAIL wb_bypass_meta got=%0d/%0d/%h exp=1/1/0", bus.out_wr, bus.out_we, bus.out_rd2); end
    wb_we = 0; step();
    checks++; if (bus.out_rd1 !== 32'h1234) begin failures++; $display("FAIL wb_rf_written got=%h exp=1234", bus.out_rd1); end
    wb_we = 1; wb_wr = 0; wb_wd = 32'hFFFF; present(2, 0, 0, 32'h84); step();
    checks++; if (bus.out_rd1 !== 0) begin failures++; $display("FAIL r0_same_cycle got=%h exp=0", bus.out_rd1); end
    wb_we = 0; step();
    checks++; if (bus.out_rd1 !== 0) begin failures++; $display("FAIL r0_after_write got=%h exp=0", bus.out_rd1); end
  endtask

  task automatic test_fwd_priority();
    idle();
    ex_we = 1; ex_wr = 7; ex_wd = 32'hA;
    mem_we = 1; mem_wr = 7; mem_wd = 32'hB;
    wb_we = 1; wb_wr = 7; wb_wd = 32'hC;
    present(1, 7, 0, 32'h90); step();
    checks++; if (bus.out_rd1 !== 32'hA) begin failures++; $display("FAIL fwd_ex got=%h exp=a", bus.out_rd1); end
    ex_we = 0; step();
    checks++; if (bus.out_rd1 !== 32'hB) begin failures++; $display("FAIL fwd_mem got=%h exp=b", bus.out_rd1); end
    mem_we = 0; step();
    checks++; if (bus.out_rd1 !== 32'hC) begin failures++; $display("FAIL fwd_wb got=%h exp=c", bus.out_rd1); end
    wb_we = 0; ex_we = 1; ex_wd = 32'hDD;
    bus.in_rf2_sel = RF2_RD; bus.in_inst = add_w(7, 0, 0); step();
    checks++; if (bus.out_rd2 !== 32'hDD || bus.out_rd1 !== 0) begin failures++; $display("FAIL fwd_rd2_sel_rd got=%h/%h exp=dd/0", bus.out_rd2, bus.out_rd1); end
  endtask

  task automatic test_load_use();
    idle(); ex_we = 1; ex_is_load = 1; ex_wr = 9; ex_wd = 32'hBAD;
    present(2, 9, 0, 32'hA0); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL loaduse_in_ready got=%0d exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0 || stall_cnt !== 1) begin failures++; $display("FAIL loaduse_bubble got=%0d/%0d exp=0/1", bus.out_valid, stall_cnt); end
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_wr = 9; mem_wd = 32'h99; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL loaduse_release got=%0d exp=1", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rd1 !== 32'h99 || stall_cnt !== 1) begin failures++; $display("FAIL loaduse_mem_fwd got=%0d/%h/%0d exp=1/99/1", bus.out_valid, bus.out_rd1, stall_cnt); end
  endtask

  task automatic test_ext();
    idle(); present(0, 0, 0, 32'hB0);
    bus.in_inst = 32'h003F_FC00; bus.in_sext_op = EXT_12S; step();
    checks++; if (bus.out_ext !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ext_12s got=%h exp=ffffffff", bus.out_ext); end
    bus.in_sext_op = EXT_12U; bus.in_is_load = 1; step();
    checks++; if (bus.out_ext !== 32'h0000_0FFF || bus.out_is_load !== 1'b1) begin failures++; $display("FAIL ext_12u got=%h/%0d exp=00000fff/1", bus.out_ext, bus.out_is_load); end
    bus.in_inst = 32'h03FF_FFFF; bus.in_sext_op = EXT_26; step();
    checks++; if (bus.out_ext !== 32'hFFFF_FFFC) begin failures++; $display("FAIL ext_26 got=%h exp=fffffffc", bus.out_ext); end
    bus.in_sext_op = 3'd7; step();
    checks++; if (bus.out_ext !== 0) begin failures++; $display("FAIL ext_other got=%h exp=0", bus.out_ext); end
  endtask

  task automatic test_backpressure();
    idle(); present(5, 0, 0, 32'h100); step();
    bus.out_ready = 0; present(6, 0, 0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0d exp=0", i, bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_wr !== 5'd5) begin failures++; $display("FAIL bp_hold[%0d] got=%0d/%h/%0d exp=1/100/5", i, bus.out_valid, bus.out_pc, bus.out_wr); end
    end
    bus.out_ready = 1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0d exp=1", bus.in_ready); end
    step();
    checks++; if (bus.out_pc !== 32'h200 || bus.out_wr !== 5'd6) begin failures++; $display("FAIL bp_next got=%h/%0d exp=200/6", bus.out_pc, bus.out_wr); end
  endtask

  task automatic test_flush();
    idle(); present(1, 2, 3, 32'h300); step();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0d exp=1", bus.out_valid); end
    ex_we = 1; ex_is_load = 1; ex_wr = 9; present(1, 9, 0, 32'h304); flush = 1; #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0d exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0 || stall_cnt !== 1) begin failures++; $display("FAIL flush_haz got=%0d/%0d exp=0/1", bus.out_valid, stall_cnt); end
    flush = 0; step();
    checks++; if (stall_cnt !== 2) begin failures++; $display("FAIL flush_after got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_random();
    int r1, r2;
    logic haz, adv, rdy;
    logic [31:0] e1, e2, ee;
    idle(); rst = 1; step(); rst = 0;
    mv = 0; m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      bus.in_valid   = $urandom_range(0, 3) != 0;
      bus.in_inst    = $urandom;
      bus.in_inst[4:0]   = 5'($urandom_range(0, 3));
      bus.in_inst[9:5]   = 5'($urandom_range(0, 3));
      bus.in_inst[14:10] = 5'($urandom_range(0, 3));
      bus.in_pc      = $urandom;
      bus.in_sext_op = 3'($urandom_range(0, 7));
      bus.in_rf2_sel = 1'($urandom_range(0, 1));
      bus.in_use1 = 1'($urandom_range(0, 1)); bus.in_use2 = 1'($urandom_range(0, 1));
      bus.in_we   = 1'($urandom_range(0, 1)); bus.in_is_load = 1'($urandom_range(0, 1));
      bus.out_ready = $urandom_range(0, 2) != 0;
      ex_we  = 1'($urandom_range(0, 1)); ex_is_load = 1'($urandom_range(0, 1));
      ex_wr  = 5'($urandom_range(0, 3)); ex_wd = $urandom;
      mem_we = 1'($urandom_range(0, 1)); mem_wr = 5'($urandom_range(0, 3)); mem_wd = $urandom;
      wb_we  = 1'($urandom_range(0, 1)); wb_wr  = 5'($urandom_range(0, 3)); wb_wd  = $urandom;
      flush  = $urandom_range(0, 15) == 0;
      #1;
      r1 = int'(bus.in_inst[9:5]);
      r2 = bus.in_rf2_sel ? int'(bus.in_inst[4:0]) : int'(bus.in_inst[14:10]);
      haz = bus.in_valid && ex_is_load && ex_we && ex_wr != 0 &&
            ((bus.in_use1 && r1 == int'(ex_wr)) || (bus.in_use2 && r2 == int'(ex_wr)));
      adv = bus.out_ready || !mv;
      rdy = adv && !haz && !flush;
      checks++; if (bus.in_ready !== rdy) begin failures++; $display("FAIL rnd_in_ready[%0d] got=%0d exp=%0d", n, bus.in_ready, rdy); end
      e1 = exp_src(r1); e2 = exp_src(r2); ee = exp_ext(bus.in_sext_op, bus.in_inst);
      if (flush) mv = 0;
      else if (adv && bus.in_valid && !haz) begin
        mv = 1; m_pc = bus.in_pc; m_rd1 = e1; m_rd2 = e2; m_ext = ee;
        m_wr = bus.in_inst[4:0]; m_we = bus.in_we; m_ld = bus.in_is_load;
      end else if (adv) mv = 0;
      if (haz && !flush) m_cnt = m_cnt + 1;
      step();
      checks++; if (bus.out_valid !== mv || stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_state[%0d] got=%0d/%0d exp=%0d/%0d", n, bus.out_valid, stall_cnt, mv, m_cnt); end
      if (mv) begin
        checks++;
        if (bus.out_pc !== m_pc || bus.out_rd1 !== m_rd1 || bus.out_rd2 !== m_rd2 || bus.out_ext !== m_ext ||
            bus.out_wr !== m_wr || bus.out_we !== m_we || bus.out_is_load !== m_ld) begin
          failures++;
          $display("FAIL rnd_payload[%0d] got=%h/%h/%h/%h/%0d/%0d/%0d exp=%h/%h/%h/%h/%0d/%0d/%0d", n,
                   bus.out_pc, bus.out_rd1, bus.out_rd2, bus.out_ext, bus.out_wr, bus.out_we, bus.out_is_load,
                   m_pc, m_rd1, m_rd2, m_ext, m_wr, m_we, m_ld);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_fwd_priority();
    test_load_use();
    test_ext();
    test_backpressure();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
